reg_writeback_queue: RTL and testbench

//  Write-side front end for register_file: buffers writeback results (ALU/load) in a small FIFO
//  and drives the register file write port (RegWrite/write1/data_in) at one write per cycle.

---
 rtl/reg_writeback_queue_if.sv | 33 +++
 rtl/reg_writeback_queue.sv | 118 +++++++++++
 tb/tb_reg_writeback_queue.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_writeback_queue_if.sv
// Bus bundle for the writeback queue: WB-side handshake, register file write port and
// the two decode-side forwarding lookups.
interface reg_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic          wr_stall;
  logic          RegWrite;
  logic [AW-1:0] write1;
  logic [DW-1:0] data_in;
  logic [AW-1:0] read_add1;
  logic [AW-1:0] read_add2;
  logic          fwd_hit1;
  logic [DW-1:0] fwd_data1;
  logic          fwd_hit2;
  logic [DW-1:0] fwd_data2;

  // Handshake: a writeback transfers on a posedge where wb_valid && wb_ready;
  // wb_ready depends only on queue fullness, and a held offer keeps its dest/data stable.
  modport master (
    output wb_valid, wb_dest, wb_data, wr_stall, read_add1, read_add2,
    input  wb_ready, RegWrite, write1, data_in, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
  );

  modport slave (
    input  wb_valid, wb_dest, wb_data, wr_stall, read_add1, read_add2,
    output wb_ready, RegWrite, write1, data_in, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Writeback FIFO in front of the register file: one registered write per cycle, plus
// forwarding of the newest pending value for the two decode read addresses.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  reg_writeback_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_dest [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] fdata1;
  logic [DW-1:0] fdata2;
  logic [PW-1:0] idx;

  assign full         = (cnt == CW'(DEPTH));
  assign empty        = (cnt == '0);
  assign count        = cnt;
  assign bus.wb_ready = !full;

  // Writes to register 0 are consumed by the handshake but never stored.
  assign push = bus.wb_valid && !full && (bus.wb_dest != '0);
  assign pop  = !empty && !bus.wr_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wr_ptr] <= bus.wb_dest;
      q_data[wr_ptr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= q_dest[rd_ptr];
        wr_data_q <= q_data[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end else begin
        wr_en_q <= 1'b0;
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign bus.RegWrite = wr_en_q;
  assign bus.write1   = wr_addr_q;
  assign bus.data_in  = wr_data_q;

  // Scan oldest to youngest so later (younger) matches overwrite; in-flight write is lowest.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    fdata1 = '0;
    fdata2 = '0;
    idx    = '0;
    if (wr_en_q && (wr_addr_q == bus.read_add1)) begin
      hit1   = 1'b1;
      fdata1 = wr_data_q;
    end
    if (wr_en_q && (wr_addr_q == bus.read_add2)) begin
      hit2   = 1'b1;
      fdata2 = wr_data_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < cnt) begin
        if (q_dest[idx] == bus.read_add1) begin
          hit1   = 1'b1;
          fdata1 = q_data[idx];
        end
        if (q_dest[idx] == bus.read_add2) begin
          hit2   = 1'b1;
          fdata2 = q_data[idx];
        end
      end
    end
    if (bus.read_add1 == '0) begin
      hit1   = 1'b0;
      fdata1 = '0;
    end
    if (bus.read_add2 == '0) begin
      hit2   = 1'b0;
      fdata2 = '0;
    end
  end

  assign bus.fwd_hit1  = hit1;
  assign bus.fwd_data1 = fdata1;
  assign bus.fwd_hit2  = hit2;
  assign bus.fwd_data2 = fdata2;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a driver issues writebacks, a negedge monitor
// checks every register file write against the expected queue.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic       clk;
  logic       reset;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  logic [AW+DW-1:0] exp_q[$];

  reg_writeback_queue_if #(.AW(AW), .DW(DW)) bus ();

  reg_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one writeback for a single edge and record it if it was accepted.
  task automatic offer(input logic [AW-1:0] dest, input logic [DW-1:0] data);
    logic acc;
    bus.wb_valid = 1'b1;
    bus.wb_dest  = dest;
    bus.wb_data  = data;
    acc = bus.wb_ready;
    tick();
    bus.wb_valid = 1'b0;
    if (acc && dest != '0) exp_q.push_back({dest, data});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && bus.RegWrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got R%0d=%0d expected no write", bus.write1, bus.data_in);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("write_dest", 64'(bus.write1), 64'(e[AW+DW-1:DW]));
        chk("write_data", 64'(bus.data_in), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    bus.wb_valid  = 1'b0;
    bus.wb_dest   = '0;
    bus.wb_data   = '0;
    bus.wr_stall  = 1'b0;
    bus.read_add1 = '0;
    bus.read_add2 = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("rst_write1", 64'(bus.write1), 64'd0);
    chk("rst_data_in", 64'(bus.data_in), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ready", 64'(bus.wb_ready), 64'd1);

    // 1: single write, one cycle latency, one cycle wide
    offer(5'd10, 32'd50);
    chk("t1_no_bypass", 64'(bus.RegWrite), 64'd0);
    chk("t1_count", 64'(count), 64'd1);
    tick();
    chk("t1_regwrite", 64'(bus.RegWrite), 64'd1);
    chk("t1_write1", 64'(bus.write1), 64'd10);
    chk("t1_data_in", 64'(bus.data_in), 64'd50);
    chk("t1_empty", 64'(empty), 64'd1);
    tick();
    chk("t1_one_wide", 64'(bus.RegWrite), 64'd0);
    chk("t1_hold_write1", 64'(bus.write1), 64'd10);

    // 2: register 0 is accepted but dropped
    chk("t2_ready", 64'(bus.wb_ready), 64'd1);
    offer(5'd0, 32'd123);
    chk("t2_count", 64'(count), 64'd0);
    bus.read_add1 = 5'd0;
    #1;
    chk("t2_fwd_hit1", 64'(bus.fwd_hit1), 64'd0);
    chk("t2_fwd_data1", 64'(bus.fwd_data1), 64'd0);
    tick();
    chk("t2_no_write", 64'(bus.RegWrite), 64'd0);

    // 3: fill while stalled, held 5th offer, forwarding, in-order drain
    bus.wr_stall = 1'b1;
    offer(5'd1, 32'd111);
    offer(5'd2, 32'd222);
    offer(5'd3, 32'd333);
    offer(5'd4, 32'd444);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ready", 64'(bus.wb_ready), 64'd0);
    chk("t3_count", 64'(count), 64'd4);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 5'd9;
    bus.wb_data  = 32'd999;
    tick();
    chk("t3_held_count", 64'(count), 64'd4);
    bus.read_add1 = 5'd3;
    #1;
    chk("t3_fwd_hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("t3_fwd_data1", 64'(bus.fwd_data1), 64'd333);
    bus.wr_stall = 1'b0;
    tick();
    chk("t3_pop1_regwrite", 64'(bus.RegWrite), 64'd1);
    chk("t3_pop1_write1", 64'(bus.write1), 64'd1);
    chk("t3_full_after_pop", 64'(full), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    exp_q.push_back({5'd9, 32'd999});
    chk("t3_pop2_write1", 64'(bus.write1), 64'd2);
    chk("t3_pop2_regwrite", 64'(bus.RegWrite), 64'd1);
    tick();
    chk("t3_pop3_write1", 64'(bus.write1), 64'd3);
    chk("t3_pop3_regwrite", 64'(bus.RegWrite), 64'd1);
    tick();
    chk("t3_pop4_write1", 64'(bus.write1), 64'd4);
    chk("t3_pop4_regwrite", 64'(bus.RegWrite), 64'd1);
    tick();
    chk("t3_pop5_write1", 64'(bus.write1), 64'd9);
    tick();
    chk("t3_drained", 64'(empty), 64'd1);
    chk("t3_idle", 64'(bus.RegWrite), 64'd0);

    // 4: youngest pending value wins
    bus.wr_stall = 1'b1;
    offer(5'd5, 32'd1);
    offer(5'd5, 32'd2);
    bus.read_add2 = 5'd5;
    #1;
    chk("t4_fwd_hit2", 64'(bus.fwd_hit2), 64'd1);
    chk("t4_fwd_data2", 64'(bus.fwd_data2), 64'd2);
    bus.wr_stall = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_drained", 64'(empty), 64'd1);

    // 5: reset during the first write discards the rest
    offer(5'd7, 32'd70);
    offer(5'd8, 32'd80);
    chk("t5_regwrite", 64'(bus.RegWrite), 64'd1);
    chk("t5_write1", 64'(bus.write1), 64'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("t5_rst_regwrite", 64'(bus.RegWrite), 64'd0);
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_write1", 64'(bus.write1), 64'd0);
    bus.read_add1 = 5'd8;
    #1;
    chk("t5_no_fwd", 64'(bus.fwd_hit1), 64'd0);
    tick();
    chk("t5_no_r8", 64'(bus.RegWrite), 64'd0);

    // 6: push and pop on the same edge, forwarding from the in-flight write
    offer(5'd11, 32'd1100);
    chk("t6_count1", 64'(count), 64'd1);
    offer(5'd12, 32'd1200);
    chk("t6_count_kept", 64'(count), 64'd1);
    chk("t6_regwrite", 64'(bus.RegWrite), 64'd1);
    bus.read_add1 = 5'd11;
    bus.read_add2 = 5'd12;
    #1;
    chk("t6_fwd_hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("t6_fwd_data1", 64'(bus.fwd_data1), 64'd1100);
    chk("t6_fwd_hit2", 64'(bus.fwd_hit2), 64'd1);
    chk("t6_fwd_data2", 64'(bus.fwd_data2), 64'd1200);

    // Drain and check nothing expected is left behind
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
